// File: rtl/fb_rect_fill.sv
// fb_rect_fill: rectangle-fill engine for the 640x480 RGB111 framebuffer.
// Takes one fill command at a time and streams pixel writes in raster order.
// The pixel address is y*H_RES + x and the data is {r,g,b}. The fill area is
// clipped to the screen. One pixel is written per clock when the framebuffer
// accepts every write.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake; ready only while idle
//   cmd_x/y/w/h/rgb   rectangle origin, size and fill colour
//   fb_write_en       write request; held until fb_write_ready accepts it
//   fb_write_ready    framebuffer accepts the presented write this cycle
//   fb_write_addr     pixel address presented with fb_write_en
//   fb_write_data     pixel colour presented with fb_write_en
//   busy              high whenever the engine is not idle
//   done              one-cycle pulse when a command completes
module fb_rect_fill #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_BITS  = 19,
  parameter int COORD_BITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [COORD_BITS-1:0] cmd_x,
  input  logic [COORD_BITS-1:0] cmd_y,
  input  logic [COORD_BITS-1:0] cmd_w,
  input  logic [COORD_BITS-1:0] cmd_h,
  input  logic [2:0]            cmd_rgb,
  output logic                  fb_write_en,
  input  logic                  fb_write_ready,
  output logic [ADDR_BITS-1:0]  fb_write_addr,
  output logic [2:0]            fb_write_data,
  output logic                  busy,
  output logic                  done
);

  // Coordinates carry one extra bit so that x+w and y+h cannot wrap.
  localparam int CW = COORD_BITS + 1;
  localparam logic [CW-1:0]        H_LIM  = CW'(H_RES);
  localparam logic [CW-1:0]        V_LIM  = CW'(V_RES);
  localparam logic [ADDR_BITS-1:0] H_STEP = ADDR_BITS'(H_RES);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t                state;
  logic [COORD_BITS-1:0] x_q, y_q, w_q, h_q;
  logic [2:0]            rgb_q;
  logic [CW-1:0]         col, row, x_last, y_last;
  logic [ADDR_BITS-1:0]  row_base;

  logic [CW-1:0]         x_sum, y_sum, x_end_c, y_end_c;
  logic [ADDR_BITS-1:0]  row_base_c;
  logic                  empty_c;

  // Clip the latched rectangle against the screen. A command with zero
  // size, or one whose origin lies off screen, produces no writes at all.
  always_comb begin
    x_sum      = {1'b0, x_q} + {1'b0, w_q};
    y_sum      = {1'b0, y_q} + {1'b0, h_q};
    x_end_c    = (x_sum > H_LIM) ? H_LIM : x_sum;
    y_end_c    = (y_sum > V_LIM) ? V_LIM : y_sum;
    row_base_c = ADDR_BITS'(y_q) * H_STEP;
    empty_c    = (w_q == '0) || (h_q == '0) ||
                 ({1'b0, x_q} >= H_LIM) || ({1'b0, y_q} >= V_LIM);
  end

  // Control FSM with registered outputs. In FILL, fb_write_addr is the
  // running pixel address. It steps by one along a row. At the end of a row
  // it jumps to the next row_base plus x. It only changes on an accepted
  // write, so the request stays stable while the framebuffer stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      fb_write_en   <= 1'b0;
      fb_write_addr <= '0;
      fb_write_data <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      w_q           <= '0;
      h_q           <= '0;
      rgb_q         <= '0;
      col           <= '0;
      row           <= '0;
      x_last        <= '0;
      y_last        <= '0;
      row_base      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            x_q       <= cmd_x;
            y_q       <= cmd_y;
            w_q       <= cmd_w;
            h_q       <= cmd_h;
            rgb_q     <= cmd_rgb;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end

        SETUP: begin
          if (empty_c) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            x_last        <= x_end_c - 1'b1;
            y_last        <= y_end_c - 1'b1;
            col           <= {1'b0, x_q};
            row           <= {1'b0, y_q};
            row_base      <= row_base_c;
            fb_write_addr <= row_base_c + ADDR_BITS'(x_q);
            fb_write_data <= rgb_q;
            fb_write_en   <= 1'b1;
            state         <= FILL;
          end
        end

        FILL: begin
          if (fb_write_ready) begin
            if (col == x_last) begin
              if (row == y_last) begin
                fb_write_en <= 1'b0;
                done        <= 1'b1;
                state       <= DONE;
              end else begin
                col           <= {1'b0, x_q};
                row           <= row + 1'b1;
                row_base      <= row_base + H_STEP;
                fb_write_addr <= row_base + H_STEP + ADDR_BITS'(x_q);
              end
            end else begin
              col           <= col + 1'b1;
              fb_write_addr <= fb_write_addr + 1'b1;
            end
          end
        end

        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// tb_fb_rect_fill: scoreboard testbench for fb_rect_fill.
// The stimulus code queues the hand-computed write addresses and data for
// each command. The monitor compares every presented write against the head
// of that queue. It pops the head when the framebuffer accepts the write.
module tb_fb_rect_fill;

  localparam int ADDR_BITS  = 19;
  localparam int COORD_BITS = 10;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [COORD_BITS-1:0] cmd_x, cmd_y, cmd_w, cmd_h;
  logic [2:0]            cmd_rgb;
  logic                  fb_write_en;
  logic                  fb_write_ready;
  logic [ADDR_BITS-1:0]  fb_write_addr;
  logic [2:0]            fb_write_data;
  logic                  busy;
  logic                  done;

  int  checkCount = 0;
  int  passCount  = 0;
  int  doneSeen   = 0;
  int  expAddr[$];
  int  expData[$];
  logic prevStall = 1'b0;
  int  waited;
  int  doneBefore;
  logic readyPattern [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  fb_rect_fill #(
    .H_RES(640), .V_RES(480), .ADDR_BITS(ADDR_BITS), .COORD_BITS(COORD_BITS)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_rgb(cmd_rgb),
    .fb_write_en(fb_write_en), .fb_write_ready(fb_write_ready),
    .fb_write_addr(fb_write_addr), .fb_write_data(fb_write_data),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic pushWrite(input int addr, input int data);
    expAddr.push_back(addr);
    expData.push_back(data);
  endtask

  // Monitor: checks every presented write against the head of the
  // scoreboard. It also checks that a stalled request is not withdrawn and
  // that done never coincides with cmd_ready.
  always @(negedge clock) begin
    if (reset) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) checkOutput("write_en held while stalled", int'(fb_write_en), 1);
      if (done) begin
        doneSeen++;
        checkOutput("cmd_ready low during done", int'(cmd_ready), 0);
      end
      if (fb_write_en) begin
        checkOutput("addr inside framebuffer", int'(fb_write_addr < 19'd307200), 1);
        if (expAddr.size() == 0) begin
          checkOutput("unexpected write addr", int'(fb_write_addr), -1);
        end else begin
          checkOutput("write addr", int'(fb_write_addr), expAddr[0]);
          checkOutput("write data", int'(fb_write_data), expData[0]);
          if (fb_write_ready) begin
            void'(expAddr.pop_front());
            void'(expData.pop_front());
          end
        end
      end
      prevStall = fb_write_en && !fb_write_ready;
    end
  end

  // Offer a command from just after a rising edge and hold it until the
  // handshake edge. waited is the number of cycles the command was offered.
  task automatic applyStimulus(input int x, input int y, input int w, input int h,
                               input int rgb, output int waitedCycles);
    cmd_x     = COORD_BITS'(x);
    cmd_y     = COORD_BITS'(y);
    cmd_w     = COORD_BITS'(w);
    cmd_h     = COORD_BITS'(h);
    cmd_rgb   = 3'(rgb);
    cmd_valid = 1'b1;
    waitedCycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      waitedCycles++;
      if (cmd_ready) break;
    end
    if (!cmd_ready) checkOutput("command accept timeout", 0, 1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  // Count cycles after the handshake cycle until done appears.
  task automatic waitDone(input int latency);
    bit seen = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (done) begin
        checkOutput("done latency", i, latency);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("done timeout", 0, 1);
  endtask

  task automatic afterDone();
    @(negedge clock);
    checkOutput("cmd_ready back high", int'(cmd_ready), 1);
    checkOutput("busy back low", int'(busy), 0);
    checkOutput("all expected writes seen", expAddr.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    cmd_valid      = 1'b0;
    cmd_x          = '0;
    cmd_y          = '0;
    cmd_w          = '0;
    cmd_h          = '0;
    cmd_rgb        = '0;
    fb_write_ready = 1'b1;

    #12;
    checkOutput("reset cmd_ready", int'(cmd_ready), 1);
    checkOutput("reset fb_write_en", int'(fb_write_en), 0);
    checkOutput("reset fb_write_addr", int'(fb_write_addr), 0);
    checkOutput("reset fb_write_data", int'(fb_write_data), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 2x2 fill at (10,5)
    $display("[TB] 2x2 fill");
    pushWrite(3210, 5); pushWrite(3211, 5); pushWrite(3850, 5); pushWrite(3851, 5);
    applyStimulus(10, 5, 2, 2, 5, waited);
    waitDone(6);
    afterDone();

    // Clipped at the bottom-right corner
    $display("[TB] clipping");
    pushWrite(307198, 7); pushWrite(307199, 7);
    applyStimulus(638, 479, 5, 3, 7, waited);
    waitDone(4);
    afterDone();

    // Empty commands
    $display("[TB] empty commands");
    applyStimulus(1, 1, 0, 3, 2, waited);
    waitDone(2);
    afterDone();
    applyStimulus(700, 0, 4, 4, 2, waited);
    waitDone(2);
    afterDone();

    // Backpressure on a 1x3 row at the origin
    $display("[TB] backpressure");
    pushWrite(0, 3); pushWrite(1, 3); pushWrite(2, 3);
    applyStimulus(0, 0, 3, 1, 3, waited);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(posedge clock);
          #1 fb_write_ready = readyPattern[i];
        end
        fb_write_ready = 1'b1;
      end
      waitDone(8);
    join
    afterDone();

    // Second command offered while the first is still filling
    $display("[TB] busy rejection");
    pushWrite(640, 2); pushWrite(641, 2); pushWrite(1283, 4);
    doneBefore = doneSeen;
    applyStimulus(0, 1, 2, 1, 2, waited);
    @(posedge clock);
    #1;
    applyStimulus(3, 2, 1, 1, 4, waited);
    checkOutput("second command accepted after done", waited, 4);
    checkOutput("first command done pulse", doneSeen - doneBefore, 1);
    waitDone(3);
    afterDone();

    // Asynchronous reset in the middle of a 4x4 fill
    $display("[TB] reset mid-fill");
    pushWrite(32100, 6); pushWrite(32101, 6);
    doneBefore = doneSeen;
    applyStimulus(100, 50, 4, 4, 6, waited);
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset fb_write_en", int'(fb_write_en), 0);
    checkOutput("async reset busy", int'(busy), 0);
    checkOutput("async reset done", int'(done), 0);
    checkOutput("async reset cmd_ready", int'(cmd_ready), 1);
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b0;
    checkOutput("writes before reset", expAddr.size(), 0);
    checkOutput("no done after reset", doneSeen - doneBefore, 0);
    @(posedge clock);
    #1;
    pushWrite(1287, 1); pushWrite(1288, 1);
    applyStimulus(7, 2, 2, 1, 1, waited);
    waitDone(4);
    afterDone();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Hard stop in case a wait is never bounded by the tasks above.
  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got 0, expected 1");
    $fatal(1, "[TB] global timeout");
  end

endmodule
